// File: rtl/fwrisc_dbg_pkg.sv
// Purpose: shared types and byte codes for the register-file debug bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, command codes ('R' 0x52, 'W' 0x57),
// response codes ('K' 0x4B ok, 'E' 0x45 error, '?' 0x3F unknown command).
package fwrisc_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_REQ   = 3'd3,
        ST_ACC   = 3'd4,
        ST_RCAP  = 3'd5,
        ST_SEND  = 3'd6,
        ST_ERR   = 3'd7
    } dbg_state_t;

    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_RD) || (b == CMD_WR);
    endfunction

endpackage

// File: rtl/fwrisc_dbg_txser.sv
// Purpose: send 1..4 bytes of a 32-bit word, LSB first, as a valid/ready byte stream.
// Latency: first byte valid the cycle after start; one byte per accepted handshake.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; start ignored while busy.
//
// Ports: clock, reset (async active-low); start/word/cnt load a response
// (word must stay stable until idle); idle high when nothing left to send;
// tx_data/tx_valid/tx_ready byte stream.
module fwrisc_dbg_txser (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [2:0]  cnt,
    output logic        idle,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [1:0] idx;
    logic [2:0] rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= 2'd0;
            rem <= 3'd0;
        end else if (start && (rem == 3'd0)) begin
            idx <= 2'd0;
            rem <= cnt;
        end else if (tx_valid && tx_ready) begin
            idx <= idx + 2'd1;
            rem <= rem - 3'd1;
        end
    end

    // Byte select rather than a shift register: the word is held by the
    // owner, so the presented byte cannot change until idx advances.
    assign tx_data  = word[{idx, 3'b000} +: 8];
    assign tx_valid = (rem != 3'd0);
    assign idle     = (rem == 3'd0);

endmodule

// File: rtl/fwrisc_regfile_dbg.sv
// Purpose: byte-command debug bridge giving a host read/write access to the core register file.
// Latency: after the last command byte: 1 cycle to REQ, grant wait, 1 (write) or 2 (read) cycles, then response.
// Backpressure: rx_ready only while collecting command bytes; response bytes wait on tx_ready.
//
// Ports: clock, reset (async active-low); rx_data/rx_valid/rx_ready command bytes;
// tx_data/tx_valid/tx_ready response bytes; dbg_req/dbg_gnt port arbitration;
// dbg_raddr/dbg_rdata read port (1-cycle latency); dbg_waddr/dbg_wdata/dbg_wen write port.
// Option: FWRISC_DBG_ZERO_PROTECT_EN rejects writes to x0 with an error response
// and never touches the register file for them.
module fwrisc_regfile_dbg
    import fwrisc_dbg_pkg::*;
#(
    parameter int GNT_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_req,
    input  logic        dbg_gnt,
    output logic [5:0]  dbg_raddr,
    input  logic [31:0] dbg_rdata,
    output logic [5:0]  dbg_waddr,
    output logic [31:0] dbg_wdata,
    output logic        dbg_wen
);

    localparam int             TW      = $clog2(GNT_TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(GNT_TIMEOUT - 1);

    dbg_state_t     state, state_nxt;
    logic           rdy_en;
    logic           is_wr;
    logic [5:0]     addr;
    logic [1:0]     wcnt;
    logic [31:0]    wdata_sh;
    logic [TW-1:0]  to_cnt;
    logic [31:0]    rdata_hold;
    logic           rx_take;
    logic           zero_blk;
    logic           ld_vld;
    logic [31:0]    ld_dat;
    logic [2:0]     ld_cnt;
    logic           ser_idle;

`ifdef FWRISC_DBG_ZERO_PROTECT_EN
    assign zero_blk = (addr == 6'd0);
`else
    assign zero_blk = 1'b0;
`endif

    // rdy_en keeps rx_ready low during reset and for the cycle it releases.
    assign rx_ready = rdy_en &&
                      ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_WDATA));
    assign rx_take  = rx_valid && rx_ready;
    assign dbg_req  = (state == ST_REQ) || (state == ST_ACC) || (state == ST_RCAP);
    assign dbg_wen  = (state == ST_ACC) && is_wr;

    // Responses are loaded on the edge that enters SEND/ERR, so those states
    // only wait for the serializer to drain.
    always_comb begin
        state_nxt = state;
        ld_vld    = 1'b0;
        ld_dat    = 32'h0;
        ld_cnt    = 3'd0;
        case (state)
            ST_IDLE: begin
                if (rx_take) begin
                    if (is_cmd(rx_data)) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_SEND;
                        ld_vld    = 1'b1;
                        ld_dat    = {24'h0, RSP_BAD};
                        ld_cnt    = 3'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_take) state_nxt = is_wr ? ST_WDATA : ST_REQ;
            end
            ST_WDATA: begin
                if (rx_take && (wcnt == 2'd3)) begin
                    if (zero_blk) begin
                        state_nxt = ST_ERR;
                        ld_vld    = 1'b1;
                        ld_dat    = {24'h0, RSP_ERR};
                        ld_cnt    = 3'd1;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dbg_gnt) begin
                    state_nxt = ST_ACC;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                    ld_vld    = 1'b1;
                    ld_dat    = {24'h0, RSP_ERR};
                    ld_cnt    = 3'd1;
                end
            end
            ST_ACC: begin
                if (is_wr) begin
                    state_nxt = ST_SEND;
                    ld_vld    = 1'b1;
                    ld_dat    = {24'h0, RSP_OK};
                    ld_cnt    = 3'd1;
                end else begin
                    state_nxt = ST_RCAP;
                end
            end
            ST_RCAP: begin
                state_nxt = ST_SEND;
                ld_vld    = 1'b1;
                ld_dat    = dbg_rdata;
                ld_cnt    = 3'd4;
            end
            ST_SEND, ST_ERR: begin
                if (ser_idle) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rdy_en     <= 1'b0;
            is_wr      <= 1'b0;
            addr       <= 6'd0;
            wcnt       <= 2'd0;
            wdata_sh   <= 32'h0;
            to_cnt     <= '0;
            rdata_hold <= 32'h0;
            dbg_raddr  <= 6'd0;
            dbg_waddr  <= 6'd0;
            dbg_wdata  <= 32'h0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if ((state == ST_IDLE) && rx_take) is_wr <= (rx_data == CMD_WR);
            if ((state == ST_ADDR) && rx_take) begin
                addr <= rx_data[5:0];
                wcnt <= 2'd0;
            end
            // Little-endian payload: each new byte enters at the top.
            if ((state == ST_WDATA) && rx_take) begin
                wdata_sh <= {rx_data, wdata_sh[31:8]};
                wcnt     <= wcnt + 2'd1;
            end
            if ((state != ST_REQ) && (state_nxt == ST_REQ)) begin
                to_cnt <= '0;
            end else if ((state == ST_REQ) && !dbg_gnt) begin
                to_cnt <= to_cnt + 1'b1;
            end
            // Port addresses/data only move on a granted access, otherwise hold.
            if ((state == ST_REQ) && dbg_gnt) begin
                if (is_wr) begin
                    dbg_waddr <= addr;
                    dbg_wdata <= wdata_sh;
                end else begin
                    dbg_raddr <= addr;
                end
            end
            // Holding register doubles as the serializer source word.
            if (ld_vld) rdata_hold <= ld_dat;
        end
    end

    fwrisc_dbg_txser u_txser (
        .clock    (clock),
        .reset    (reset),
        .start    (ld_vld),
        .word     (rdata_hold),
        .cnt      (ld_cnt),
        .idle     (ser_idle),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

endmodule

// File: tb/tb_fwrisc_regfile_dbg.sv
// Bench for fwrisc_regfile_dbg: directed commands, expected response bytes and
// register writes queued at issue time, checked by an independent monitor.
module tb_fwrisc_regfile_dbg;
    import fwrisc_dbg_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_req;
    logic        gnt;
    logic [5:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [5:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        dbg_wen;

    int          n_cmp = 0;
    int          n_err = 0;
    int          req_cycles = 0;
    bit          tog_rdy = 1'b0;
    logic [7:0]  txq[$];
    logic [37:0] wq[$];
    logic [31:0] mem[64];

    fwrisc_regfile_dbg #(.GNT_TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dbg_req   (dbg_req),
        .dbg_gnt   (gnt),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .dbg_wen   (dbg_wen)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-file model: address sampled mid-cycle, data returned the next cycle.
    initial begin : regfile_model
        logic [5:0]  ra;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        we;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        dbg_rdata = 32'h0;
        forever begin
            @(negedge clock);
            ra = dbg_raddr;
            we = dbg_wen;
            wa = dbg_waddr;
            wd = dbg_wdata;
            @(posedge clock);
            #1;
            if (we && (wa != 6'd0)) mem[wa] = wd;
            dbg_rdata = mem[ra];
        end
    end

    initial begin : tx_ready_drv
        tx_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tx_ready = tog_rdy ? ~tx_ready : 1'b1;
        end
    end

    // Monitor: pops expectations on every tx handshake / write pulse.
    initial begin : monitor
        logic        stall;
        logic [7:0]  sdat;
        logic [7:0]  e;
        logic [37:0] w;
        stall = 1'b0;
        sdat  = 8'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
                    check("tx_hold_data", {24'h0, tx_data}, {24'h0, sdat});
                end
                if (tx_valid && tx_ready) begin
                    if (txq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
                    end else begin
                        e = txq.pop_front();
                        check("tx_byte", {24'h0, tx_data}, {24'h0, e});
                    end
                end
                stall = tx_valid && !tx_ready;
                sdat  = tx_data;
                if (dbg_wen) begin
                    if (wq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL wen_unexpected: got write addr %0d data 0x%0h, expected none",
                                 dbg_waddr, dbg_wdata);
                    end else begin
                        w = wq.pop_front();
                        check("wr_addr", {26'h0, dbg_waddr}, {26'h0, w[37:32]});
                        check("wr_data", dbg_wdata, w[31:0]);
                    end
                end
                if (dbg_req) req_cycles++;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && (k < 200)) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_accept: got rx_ready=0 for 200 cycles, expected 1");
        end else begin
            @(posedge clock);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(CMD_WR);
        send_byte(a);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        send_byte(d[31:24]);
    endtask

    task automatic do_read(input logic [7:0] a);
        send_byte(CMD_RD);
        send_byte(a);
    endtask

    task automatic push_word(input logic [31:0] d);
        txq.push_back(d[7:0]);
        txq.push_back(d[15:8]);
        txq.push_back(d[23:16]);
        txq.push_back(d[31:24]);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (((txq.size() != 0) || (wq.size() != 0)) && (k < 400)) begin
            @(posedge clock);
            #1;
            k++;
        end
        check({name, "_drained"}, txq.size() + wq.size(), 32'h0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin : main
        rx_valid = 1'b0;
        rx_data  = 8'h0;
        gnt      = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_dbg_req", {31'h0, dbg_req}, 32'h0);
        check("rst_dbg_wen", {31'h0, dbg_wen}, 32'h0);
        check("rst_raddr", {26'h0, dbg_raddr}, 32'h0);
        check("rst_waddr", {26'h0, dbg_waddr}, 32'h0);
        check("rst_wdata", dbg_wdata, 32'h0);
        reset = 1'b1;
        check("rx_ready_before_edge", {31'h0, rx_ready}, 32'h0);
        @(posedge clock);
        #1;
        check("rx_ready_first_edge", {31'h0, rx_ready}, 32'h1);

        // Write x5, grant tied high: REQ + ACC = 2 request cycles.
        txq.push_back(RSP_OK);
        wq.push_back({6'd5, 32'h12345678});
        req_cycles = 0;
        do_write(8'h05, 32'h12345678);
        wait_done("write5");
        check("write5_req_cycles", req_cycles, 32'd2);

        // Read x5: REQ + ACC + RCAP = 3 request cycles.
        push_word(32'h12345678);
        req_cycles = 0;
        do_read(8'h05);
        wait_done("read5");
        check("read5_req_cycles", req_cycles, 32'd3);

        // Grant withheld: exactly 16 request cycles then error, read port untouched.
        gnt = 1'b0;
        txq.push_back(RSP_ERR);
        req_cycles = 0;
        do_read(8'h03);
        wait_done("timeout");
        check("timeout_req_cycles", req_cycles, 32'd16);
        check("timeout_raddr_held", {26'h0, dbg_raddr}, 32'd5);
        gnt = 1'b1;

        // Unknown byte, then a normal read.
        txq.push_back(RSP_BAD);
        send_byte(8'h11);
        wait_done("badcmd");
        push_word(32'h12345678);
        do_read(8'h05);
        wait_done("read_after_bad");

        // Address bits [7:6] ignored: 0xC5 reads x5.
        push_word(32'h12345678);
        do_read(8'hC5);
        wait_done("read_hi_bits");

        // Read under toggling tx_ready.
        txq.push_back(RSP_OK);
        wq.push_back({6'd9, 32'hA1B2C3D4});
        do_write(8'h09, 32'hA1B2C3D4);
        wait_done("write9");
        tog_rdy = 1'b1;
        push_word(32'hA1B2C3D4);
        do_read(8'h09);
        wait_done("read9_toggle");
        tog_rdy = 1'b0;

        // Write to x0.
        req_cycles = 0;
`ifdef FWRISC_DBG_ZERO_PROTECT_EN
        txq.push_back(RSP_ERR);
        do_write(8'h00, 32'hCAFEF00D);
        wait_done("write0");
        check("write0_req_cycles", req_cycles, 32'd0);
`else
        txq.push_back(RSP_OK);
        wq.push_back({6'd0, 32'hCAFEF00D});
        do_write(8'h00, 32'hCAFEF00D);
        wait_done("write0");
        check("write0_req_cycles", req_cycles, 32'd2);
`endif

        // Reset after the second data byte: nothing written, nothing sent.
        send_byte(CMD_WR);
        send_byte(8'h07);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("midrst_wen", {31'h0, dbg_wen}, 32'h0);
        check("midrst_req", {31'h0, dbg_req}, 32'h0);
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        wait_done("midrst");
        push_word(32'h00000000);
        do_read(8'h07);
        wait_done("read7_after_rst");
        push_word(32'h12345678);
        do_read(8'h05);
        wait_done("read5_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fwrisc_regfile_dbg.md
FWRISC_REGFILE_DBG -- requirements
Module: fwrisc_regfile_dbg

Interface
REQ-001 Parameter: GNT_TIMEOUT, 255, cycles to wait for dbg_gnt before aborting with an error response.
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8; rx_valid  input  1; rx_ready  output  1: command byte stream, valid/ready.
REQ-005 tx_data  output  8; tx_valid  output  1; tx_ready  input  1: response byte stream, valid/ready.
REQ-006 dbg_req  output  1  request for exclusive register-file port access; dbg_gnt  input  1  grant from core.
REQ-007 dbg_raddr  output  6; dbg_rdata  input  32: read port; data valid one cycle after the address is presented.
REQ-008 dbg_waddr  output  6; dbg_wdata  output  32; dbg_wen  output  1: write port, written on clock edge with dbg_wen=1.

Function
REQ-009 Commands: 0x52 'R' + addr byte; 0x57 'W' + addr byte + 4 data bytes, little-endian; addr bits[5:0] used, bits[7:6] ignored.
REQ-010 Any other first byte SHALL be consumed and answered with the single byte 0x3F; FSM then returns to IDLE.
REQ-011 States: IDLE -> ADDR -> (W only) WDATA x4 -> REQ -> ACC -> (R only) RCAP -> SEND -> IDLE; any state -> ERR on timeout.
REQ-012 rx_ready SHALL be 1 only in IDLE, ADDR and WDATA; a byte is taken when rx_valid & rx_ready.
REQ-013 REQ: dbg_req asserted; held continuously through ACC and RCAP; deasserted on entry to SEND or ERR.
REQ-014 ACC: entered on first cycle dbg_gnt=1 in REQ; read drives dbg_raddr for exactly one cycle; write drives dbg_wen=1 for exactly one cycle with dbg_waddr/dbg_wdata.
REQ-015 RCAP: captures dbg_rdata into a 32-bit holding register, exactly one cycle after ACC.
REQ-016 SEND, read: 4 bytes rdata[7:0], [15:8], [23:16], [31:24] in order; write: single byte 0x4B.
REQ-017 tx_data/tx_valid SHALL hold stable while tx_valid & !tx_ready; next byte presented on the cycle after a handshake, never sooner.
REQ-018 Timeout counter clears on entry to REQ and increments each REQ cycle without dbg_gnt; reaching GNT_TIMEOUT -> ERR.
REQ-019 ERR: send 0x45, no register-file access performed, then IDLE.
REQ-020 dbg_gnt dropping during ACC/RCAP SHALL be ignored; access completes.
REQ-021 dbg_wen SHALL never assert outside ACC; dbg_raddr/dbg_waddr/dbg_wdata hold last values when idle.

Reset
REQ-022 On reset low: FSM IDLE; rx_ready=0, tx_valid=0, tx_data=0, dbg_req=0, dbg_wen=0, dbg_raddr=0, dbg_waddr=0, dbg_wdata=0; counters, holding register cleared.
REQ-023 Reset mid-command discards the partial command; no write is issued and no response is sent.
REQ-024 rx_ready SHALL rise on the first clock edge after reset deasserts.

Configuration
REQ-025 FWRISC_DBG_ZERO_PROTECT_EN defined: 'W' to address 0 SHALL skip REQ/ACC (no dbg_req, no dbg_wen), respond 0x45.
REQ-026 Macro undefined: 'W' to address 0 handled like any address (regfile keeps x0 at zero itself), respond 0x4B.

Structure
REQ-027 Shared package fwrisc_dbg_pkg: state enum, command codes 0x52/0x57, response codes 0x4B/0x45/0x3F.
REQ-028 Sub-module fwrisc_dbg_txser: 32-bit/4-byte to byte-stream serializer with valid/ready; no other sub-modules.

Verification
REQ-029 'W',0x05,0x78,0x56,0x34,0x12, gnt tied 1 -> one dbg_wen pulse, waddr=5, wdata=0x12345678; tx 0x4B.
REQ-030 Then 'R',0x05 with model regfile (1-cycle latency) -> tx 0x78,0x56,0x34,0x12 in order.
REQ-031 'R',0x03, dbg_gnt held 0, GNT_TIMEOUT=16 -> dbg_req for 16 cycles, tx 0x45, no dbg_raddr-based capture.
REQ-032 Byte 0x11 -> tx 0x3F; following 'R' command handled normally.
REQ-033 Read with tx_ready toggling 1/0 each cycle -> 4 bytes unchanged, correct order, no drops/duplicates.
REQ-034 'W',0x00,4 data bytes: with macro -> no dbg_wen, tx 0x45; without -> dbg_wen once, tx 0x4B; reset after second data byte -> no dbg_wen, no tx.
